muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit. Sits directly downstream of the register file

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by one sign-fixup cycle that writes HI/LO and pulses done.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] w_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Magnitude of v when it is a negative signed operand, raw v otherwise
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's complement negation, single width
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation, double width
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Control and architectural state
  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic              busy_q;
  logic              done_q;
  logic              dbz_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  // Operation context captured on accept
  logic              op_div_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic              b_zero_q;
  logic [WIDTH-1:0]  a_raw_q;
  logic [WIDTH-1:0]  mag_a_q;
  logic [WIDTH-1:0]  mag_b_q;

  // Iteration registers: multiply accumulator, divide remainder/quotient
  logic [2*WIDTH-1:0] mul_acc_q;
  logic [WIDTH-1:0]   div_rem_q;
  logic [WIDTH-1:0]   div_quo_q;

  // Combinational next values
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_rem_d;
  logic [WIDTH-1:0]   div_quo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi_d;
  logic [WIDTH-1:0]   res_lo_d;
  logic               res_dbz_d;

  logic accept;

  assign accept      = (state_q == S_IDLE) && start;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // One multiply step and one restoring divide step per CALC cycle
  always_comb begin
    mul_sum   = {1'b0, mul_acc_q[2*WIDTH-1:WIDTH]} + (mul_acc_q[0] ? {1'b0, mag_a_q} : '0);
    mul_acc_d = {mul_sum, mul_acc_q[WIDTH-1:1]};
    div_shift = {div_rem_q, div_quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_b_q};
    // A negative trial means the divisor did not fit: keep the shifted remainder
    div_rem_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quo_d = {div_quo_q[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // Sign fixup of the magnitude result, including divide-by-zero substitution
  always_comb begin
    prod_fix  = (neg_a_q ^ neg_b_q) ? neg_2w(mul_acc_q) : mul_acc_q;
    res_hi_d  = prod_fix[2*WIDTH-1:WIDTH];
    res_lo_d  = prod_fix[WIDTH-1:0];
    res_dbz_d = 1'b0;
    if (op_div_q) begin
      if (b_zero_q) begin
        res_lo_d  = '1;
        res_hi_d  = a_raw_q;
        res_dbz_d = 1'b1;
      end else begin
        res_lo_d = (neg_a_q ^ neg_b_q) ? neg_w(div_quo_q) : div_quo_q;
        res_hi_d = neg_a_q ? neg_w(div_rem_q) : div_rem_q;
      end
    end
  end

  // Operand capture on accept and iteration during CALC (datapath, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div_q  <= op[1];
      neg_a_q   <= op[0] & a_data[WIDTH-1];
      neg_b_q   <= op[0] & b_data[WIDTH-1];
      b_zero_q  <= (b_data == '0);
      a_raw_q   <= a_data;
      mag_a_q   <= abs_val(a_data, op[0]);
      mag_b_q   <= abs_val(b_data, op[0]);
      mul_acc_q <= {{WIDTH{1'b0}}, abs_val(b_data, op[0])};
      div_rem_q <= '0;
      div_quo_q <= abs_val(a_data, op[0]);
    end else if (state_q == S_CALC) begin
      mul_acc_q <= mul_acc_d;
      div_rem_q <= div_rem_d;
      div_quo_q <= div_quo_d;
    end
  end

  // Sequencer FSM with registered busy/done/flag and HI/LO writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            count_q <= '0;
            state_q <= S_CALC;
          end else begin
            if (wr_hi) hi_q <= w_data;
            if (wr_lo) lo_q <= w_data;
          end
        end
        S_CALC: begin
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          dbz_q   <= res_dbz_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/flag computed from a
// 64-bit arithmetic reference model and queued at issue time.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_data, b_data;
  logic        wr_hi, wr_lo;
  logic [31:0] w_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_data(a_data), .b_data(b_data),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .w_data(w_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; a_data = a; b_data = b; start = 1'b1;
    sb_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    a_data = $urandom; b_data = $urandom;
  endtask

  // Waits (bounded) for done, reports edges waited, compares against scoreboard
  task automatic wait_result(input string name, output int lat);
    exp_t e;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, lat);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected done: no result queued", name);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h, required %h", name, hi, e.hi); end
      checks++;
      if (lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h, required %h", name, lo, e.lo); end
      checks++;
      if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b, required %b", name, div_by_zero, e.dbz); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; a_data = '0; b_data = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset flags: got busy/done/dbz=%b, required 000", {busy, done, div_by_zero}); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset hilo: got hi=%h lo=%h, required 0/0", hi, lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat;
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL multu busy after accept: got %b, required 1", busy); end
    wait_result("multu_max", lat);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL multu latency: got %0d edges, required 33", lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL multu busy at done: got %b, required 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL multu done width: got done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_signed();
    int lat;
    logic [1:0]  o;
    logic [31:0] a, b;
    issue(2'd1, 32'hFFFF_FFFD, 32'd5);         wait_result("mult_neg3x5", lat);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);         wait_result("div_neg7by2", lat);
    issue(2'd3, 32'd7, 32'hFFFF_FFFE);         wait_result("div_7byneg2", lat);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("div_overflow", lat);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000); wait_result("mult_minxmin", lat);
    issue(2'd2, 32'hFFFF_FFFF, 32'd10);        wait_result("divu_big", lat);
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      issue(o, a, b);
      wait_result("random_op", lat);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(2'd2, 32'd100, 32'd0);
    wait_result("divu_by_zero", lat);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL div0 latency: got %0d edges, required 33", lat); end
    @(posedge clk); #1;
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL div0 flag hold: got %b, required 1", div_by_zero); end
    issue(2'd0, 32'd2, 32'd3);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div0 clear on accept: got %b, required 0", div_by_zero); end
    wait_result("multu_after_div0", lat);
    issue(2'd3, 32'hFFFF_FFFB, 32'd0);
    wait_result("div_neg_by_zero", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'd0, 32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #1;
    op = 2'd3; a_data = 32'hDEAD_BEEF; b_data = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignored start busy: got %b, required 1", busy); end
    wait_result("start_while_busy", lat);
    checks++;
    if (lat != 22) begin errors++; $display("FAIL ignored start latency: got %0d edges, required 22", lat); end
    issue(2'd1, 32'hFFFF_FF00, 32'd77);
    wait_result("issue_in_done_cycle", lat);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL back-to-back latency: got %0d edges, required 33", lat); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    exp_t e;
    issue(2'd0, 32'h0001_0001, 32'h0000_FFFF);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset flags: got busy/done=%b, required 00", {busy, done}); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset hilo: got hi=%h lo=%h, required 0/0", hi, lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    if (sb_q.size() > 0) e = sb_q.pop_back();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset ghost op: got activity=%b after release, required 0", seen); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset no result: got hi=%h lo=%h, required 0/0", hi, lo); end
  endtask

  task automatic test_hilo_write();
    int lat;
    wr_hi = 1'b1; wr_lo = 1'b1; w_data = 32'h1234_5678;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin errors++; $display("FAIL idle write: got hi=%h lo=%h, required 12345678/12345678", hi, lo); end
    wr_hi = 1'b1; w_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'h1234_5678) begin errors++; $display("FAIL hi-only write: got hi=%h lo=%h, required cafef00d/12345678", hi, lo); end
    wr_hi = 1'b1; wr_lo = 1'b1; w_data = 32'hAAAA_AAAA;
    issue(2'd0, 32'd3, 32'd4);
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'h1234_5678) begin errors++; $display("FAIL write with start: got hi=%h lo=%h, required cafef00d/12345678", hi, lo); end
    w_data = 32'h5555_5555;
    repeat (3) @(posedge clk);
    #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'h1234_5678) begin errors++; $display("FAIL write while busy: got hi=%h lo=%h, required cafef00d/12345678", hi, lo); end
    wait_result("multu_after_writes", lat);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin errors++; $display("FAIL hilo hold: got hi=%h lo=%h, required 00000000/0000000c", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_hilo_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
